// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, fetch FSM encoding and the canonical NOP.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response channel; master is the fetch sequencer, slave the memory.
interface fetch_ctrl_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with a one-cycle clear; the head entry is read straight from storage.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues credit-limited requests at pc, buffers in-order responses for decode,
// and squashes buffered and in-flight fetches on an execute-stage redirect.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc,
  output logic             ifu_stall,
  input  logic             ex_redirect,
  fetch_ctrl_if.master     imem,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_instr,
  output logic [XLEN-1:0]  if_pc,
  input  logic             id_ready,
  output logic             flush
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] ST_INIT  = 2'(INIT);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic              flush_q, flush_d;

  logic [CW-1:0]     aq_count, ib_count, credits_s, redir_discard_s;
  logic              aq_full, aq_empty, ib_full, ib_empty;
  logic [XLEN-1:0]   aq_head;
  logic [2*XLEN-1:0] ib_head;
  logic              redirect_s, req_s, accept_s, rsp_run_s, ib_pop_s;

  assign redirect_s = ex_redirect && (state_q != ST_INIT);
  assign ib_pop_s   = !ib_empty && id_ready;
  // An entry decode takes this cycle frees its credit at once, giving 1 fetch/cycle at DEPTH=2.
  assign credits_s  = aq_count + ib_count - {{(CW-1){1'b0}}, ib_pop_s};
  assign req_s      = (state_q == ST_RUN) && (credits_s < CW'(DEPTH)) && !ex_redirect && !aq_full;
  assign accept_s   = req_s && imem.imem_ready;
  assign rsp_run_s  = (state_q == ST_RUN) && imem.imem_rvalid && !aq_empty;
  assign redir_discard_s = aq_count - {{(CW-1){1'b0}}, rsp_run_s};

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc;
  assign ifu_stall      = !accept_s && !ex_redirect;
  assign if_valid       = !ib_empty;
  assign if_pc          = ib_empty ? RESET_PC : ib_head[2*XLEN-1:XLEN];
  assign if_instr       = ib_empty ? {XLEN{1'b0}} : ib_head[XLEN-1:0];
  assign flush          = flush_q;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_s),
    .push  (accept_s),
    .pop   (rsp_run_s),
    .wdata (pc),
    .rdata (aq_head),
    .count (aq_count),
    .full  (aq_full),
    .empty (aq_empty)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_s),
    .push  (rsp_run_s && !ib_full),
    .pop   (ib_pop_s),
    .wdata ({aq_head, imem.imem_rdata}),
    .rdata (ib_head),
    .count (ib_count),
    .full  (ib_full),
    .empty (ib_empty)
  );

  // FSM transitions and stale-response accounting.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    flush_d   = redirect_s;
    case (state_q)
      ST_INIT: begin
        state_d   = ST_RUN;
        discard_d = {CW{1'b0}};
      end
      ST_RUN: begin
        if (redirect_s) begin
          discard_d = redir_discard_s;
          state_d   = (redir_discard_s != {CW{1'b0}}) ? ST_DRAIN : ST_RUN;
        end else begin
          discard_d = {CW{1'b0}};
          state_d   = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (imem.imem_rvalid && (discard_q != {CW{1'b0}})) begin
          discard_d = discard_q - CW'(1);
        end else begin
          discard_d = discard_q;
        end
        state_d = (discard_d == {CW{1'b0}}) ? ST_RUN : ST_DRAIN;
      end
      default: begin
        state_d   = ST_INIT;
        discard_d = {CW{1'b0}};
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      discard_q <= {CW{1'b0}};
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      flush_q   <= flush_d;
    end
  end

endmodule
